// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the fetch stage, the memory stage,
// the shared memory port and the mem_arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          IReqF;
    logic [AW-1:0] IAdrF;
    logic          FlushF;
    logic [DW-1:0] IRdataF;
    logic          IValidF;
    logic          StallF;

    logic            DReqM;
    logic            DWeM;
    logic [AW-1:0]   DAdrM;
    logic [DW-1:0]   DWdataM;
    logic [DW/8-1:0] DBeM;
    logic [DW-1:0]   DRdataM;
    logic            DValidM;
    logic            StallM;

    logic            MemReq;
    logic            MemWe;
    logic [AW-1:0]   MemAdr;
    logic [DW-1:0]   MemWdata;
    logic [DW/8-1:0] MemBe;
    logic            MemReady;
    logic [DW-1:0]   MemRdata;

    modport master (
        input  IReqF, IAdrF, FlushF,
        input  DReqM, DWeM, DAdrM, DWdataM, DBeM,
        input  MemReady, MemRdata,
        output IRdataF, IValidF, StallF,
        output DRdataM, DValidM, StallM,
        output MemReq, MemWe, MemAdr, MemWdata, MemBe
    );

    modport slave (
        output IReqF, IAdrF, FlushF,
        output DReqM, DWeM, DAdrM, DWdataM, DBeM,
        output MemReady, MemRdata,
        input  IRdataF, IValidF, StallF,
        input  DRdataM, DValidM, StallM,
        input  MemReq, MemWe, MemAdr, MemWdata, MemBe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port unified memory.
// Define MEMARB_RR_EN for round-robin IDLE grants (default: data first).
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.master bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_i;
    logic          grant_d;
    logic          fetch_ok;
    logic          idle_pick_d;
    logic          squash;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdata_q;
    logic [BW-1:0] be_q;

    assign fetch_ok = bus.IReqF & ~bus.FlushF;

`ifdef MEMARB_RR_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_i) begin
            last_d <= 1'b0;
        end
    end

    // On a tie, the requester that lost last time wins.
    assign idle_pick_d = bus.DReqM & ~(fetch_ok & last_d);
`else
    assign idle_pick_d = bus.DReqM;
`endif

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (idle_pick_d) begin
                    grant_d = 1'b1;
                end else if (fetch_ok) begin
                    grant_i = 1'b1;
                end
            end
            IBUSY: begin
                if (bus.MemReady) begin
                    if (bus.DReqM) grant_d = 1'b1;
                    else           state_nxt = IDLE;
                end
            end
            DBUSY: begin
                if (bus.MemReady) begin
                    if (fetch_ok) grant_i = 1'b1;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_d) begin
            state_nxt = DBUSY;
        end else if (grant_i) begin
            state_nxt = IBUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant_d) begin
            we_q    <= bus.DWeM;
            adr_q   <= bus.DAdrM;
            wdata_q <= bus.DWdataM;
            be_q    <= bus.DBeM;
        end else if (grant_i) begin
            we_q    <= 1'b0;
            adr_q   <= bus.IAdrF;
            wdata_q <= '0;
            be_q    <= '1;
        end
    end

    // A stale fetch still runs to completion; only its valid is hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            squash <= 1'b0;
        end else if (grant_i) begin
            squash <= 1'b0;
        end else if (state == IBUSY && bus.FlushF) begin
            squash <= 1'b1;
        end
    end

    assign bus.MemReq   = (state != IDLE);
    assign bus.MemWe    = we_q;
    assign bus.MemAdr   = adr_q;
    assign bus.MemWdata = wdata_q;
    assign bus.MemBe    = be_q;

    assign bus.IValidF = (state == IBUSY) & bus.MemReady & ~squash;
    assign bus.DValidM = (state == DBUSY) & bus.MemReady;
    assign bus.IRdataF = bus.MemRdata;
    assign bus.DRdataM = bus.MemRdata;
    assign bus.StallF  = bus.IReqF & ~bus.IValidF;
    assign bus.StallM  = bus.DReqM & ~bus.DValidM;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level model,
// plus directed scenarios pinned by literal expectations.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, want, $time);
        end
    endtask

    // Model: who owns the memory now (0 none, 1 fetch, 2 data) and
    // the transaction that was handed to memory at grant.
    int          owner = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_be = '0;
    bit          m_squash = 1'b0;
    bit          m_last_d = 1'b0;

    always @(posedge clk) begin : model
        bit fok, gd, gi;
        if (reset) begin
            owner = 0; m_we = 0; m_adr = 0; m_wd = 0; m_be = 0;
            m_squash = 0; m_last_d = 0;
        end else begin
            fok = bus.IReqF && !bus.FlushF;
            gd = 0;
            gi = 0;
            if (owner == 1 && bus.FlushF) m_squash = 1;
            if (owner == 0) begin
                if (bus.DReqM && fok) begin
                    gd = RR ? !m_last_d : 1'b1;
                    gi = !gd;
                end else begin
                    gd = bus.DReqM;
                    gi = fok;
                end
            end else if (bus.MemReady) begin
                if (owner == 1) gd = bus.DReqM;
                else            gi = fok;
                owner = 0;
            end
            if (gd) begin
                owner = 2; m_we = bus.DWeM; m_adr = bus.DAdrM;
                m_wd = bus.DWdataM; m_be = bus.DBeM; m_last_d = 1;
            end
            if (gi) begin
                owner = 1; m_we = 0; m_adr = bus.IAdrF;
                m_be = 4'hF; m_squash = 0; m_last_d = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit e_iv, e_dv;
        if (run_cmp) begin
            e_iv = owner == 1 && bus.MemReady && !m_squash;
            e_dv = owner == 2 && bus.MemReady;
            chk("MemReq", bus.MemReq, owner != 0);
            chk("MemAdr", bus.MemAdr, m_adr);
            chk("MemWe", bus.MemWe, m_we);
            chk("MemBe", bus.MemBe, m_be);
            if (owner == 2 && m_we) chk("MemWdata", bus.MemWdata, m_wd);
            chk("IValidF", bus.IValidF, e_iv);
            chk("DValidM", bus.DValidM, e_dv);
            chk("StallF", bus.StallF, bus.IReqF && !e_iv);
            chk("StallM", bus.StallM, bus.DReqM && !e_dv);
            if (e_iv) chk("IRdataF", bus.IRdataF, bus.MemRdata);
            if (e_dv) chk("DRdataM", bus.DRdataM, bus.MemRdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    bit          iv, dv;
    logic [31:0] want_adr;

    initial begin
        bus.IReqF = 0; bus.IAdrF = 0; bus.FlushF = 0;
        bus.DReqM = 0; bus.DWeM = 0; bus.DAdrM = 0;
        bus.DWdataM = 0; bus.DBeM = 0;
        bus.MemReady = 0; bus.MemRdata = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        run_cmp = 1'b1;

        // single fetch with zero wait states
        bus.IReqF = 1; bus.IAdrF = 32'h100;
        bus.MemReady = 1; bus.MemRdata = 32'h1111_2222;
        @(negedge clk);
        chk("rst_memreq", bus.MemReq, 0);
        chk("rst_memadr", bus.MemAdr, 0);
        chk("rst_memwdata", bus.MemWdata, 0);
        chk("rst_membe", bus.MemBe, 0);
        chk("rst_memwe", bus.MemWe, 0);
        chk("rst_ivalid", bus.IValidF, 0);
        chk("rst_dvalid", bus.DValidM, 0);
        chk("t1_stallf_c0", bus.StallF, 1);
        tick();
        @(negedge clk);
        chk("t1_memreq", bus.MemReq, 1);
        chk("t1_memadr", bus.MemAdr, 32'h100);
        chk("t1_membe", bus.MemBe, 4'hF);
        chk("t1_ivalid", bus.IValidF, 1);
        chk("t1_irdata", bus.IRdataF, 32'h1111_2222);
        chk("t1_stallf_c1", bus.StallF, 0);
        tick();
        bus.IReqF = 0;
        @(negedge clk);
        chk("t1_idle", bus.MemReq, 0);

        // store with three wait states
        bus.DReqM = 1; bus.DWeM = 1; bus.DAdrM = 32'h2000;
        bus.DWdataM = 32'hDEAD_BEEF; bus.DBeM = 4'h3; bus.MemReady = 0;
        @(negedge clk);
        chk("t2_stallm_c0", bus.StallM, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wait_adr", bus.MemAdr, 32'h2000);
            chk("t2_wait_wdata", bus.MemWdata, 32'hDEAD_BEEF);
            chk("t2_wait_be", bus.MemBe, 4'h3);
            chk("t2_wait_we", bus.MemWe, 1);
            chk("t2_wait_dvalid", bus.DValidM, 0);
            chk("t2_wait_stallm", bus.StallM, 1);
            tick();
        end
        bus.MemReady = 1;
        @(negedge clk);
        chk("t2_done_adr", bus.MemAdr, 32'h2000);
        chk("t2_done_wdata", bus.MemWdata, 32'hDEAD_BEEF);
        chk("t2_done_dvalid", bus.DValidM, 1);
        chk("t2_done_stallm", bus.StallM, 0);
        tick();
        bus.DReqM = 0; bus.DWeM = 0;
        @(negedge clk);
        chk("t2_idle", bus.MemReq, 0);
        chk("t2_no_dvalid", bus.DValidM, 0);

        // simultaneous requests: data first, fetch handed off directly
        pulse_reset();
        bus.IReqF = 1; bus.IAdrF = 32'h300;
        bus.DReqM = 1; bus.DAdrM = 32'h400; bus.DWeM = 0;
        bus.MemReady = 1; bus.MemRdata = 32'hCAFE_0001;
        tick();
        @(negedge clk);
        chk("t3_d_adr", bus.MemAdr, 32'h400);
        chk("t3_d_valid", bus.DValidM, 1);
        chk("t3_d_rdata", bus.DRdataM, 32'hCAFE_0001);
        chk("t3_i_wait", bus.IValidF, 0);
        chk("t3_stallf", bus.StallF, 1);
        tick();
        bus.DReqM = 0; bus.MemRdata = 32'hCAFE_0002;
        @(negedge clk);
        chk("t3_i_req", bus.MemReq, 1);
        chk("t3_i_adr", bus.MemAdr, 32'h300);
        chk("t3_i_valid", bus.IValidF, 1);
        chk("t3_i_rdata", bus.IRdataF, 32'hCAFE_0002);
        tick();
        bus.IReqF = 0;
        @(negedge clk);
        chk("t3_idle", bus.MemReq, 0);

        // flush during a fetch hides the stale completion
        bus.IReqF = 1; bus.IAdrF = 32'h40; bus.MemReady = 0;
        tick();
        bus.FlushF = 1; bus.IAdrF = 32'h80;
        @(negedge clk);
        chk("t4_busy_adr", bus.MemAdr, 32'h40);
        chk("t4_busy_valid", bus.IValidF, 0);
        tick();
        bus.FlushF = 0; bus.MemReady = 1; bus.MemRdata = 32'h0BAD_0040;
        @(negedge clk);
        chk("t4_stale_req", bus.MemReq, 1);
        chk("t4_stale_adr", bus.MemAdr, 32'h40);
        chk("t4_stale_valid", bus.IValidF, 0);
        tick();
        @(negedge clk);
        chk("t4_gap_req", bus.MemReq, 0);
        chk("t4_gap_valid", bus.IValidF, 0);
        tick();
        bus.MemRdata = 32'hB0B0_0080;
        @(negedge clk);
        chk("t4_new_adr", bus.MemAdr, 32'h80);
        chk("t4_new_valid", bus.IValidF, 1);
        chk("t4_new_rdata", bus.IRdataF, 32'hB0B0_0080);
        tick();
        bus.IReqF = 0;
        @(negedge clk);
        chk("t4_idle", bus.MemReq, 0);

        // reset abandons an in-flight data access
        bus.DReqM = 1; bus.DWeM = 0; bus.DAdrM = 32'h500; bus.MemReady = 0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", bus.MemReq, 1);
        tick();
        reset = 1'b0; bus.DReqM = 0; bus.MemReady = 1;
        @(negedge clk);
        chk("t5_req", bus.MemReq, 0);
        chk("t5_adr", bus.MemAdr, 0);
        chk("t5_dvalid", bus.DValidM, 0);
        tick();
        @(negedge clk);
        chk("t5_req2", bus.MemReq, 0);
        chk("t5_dvalid2", bus.DValidM, 0);
        chk("t5_ivalid2", bus.IValidF, 0);

        // both held: grants alternate D, I, D, I ...
        pulse_reset();
        bus.IReqF = 1; bus.IAdrF = 32'h600;
        bus.DReqM = 1; bus.DAdrM = 32'h700; bus.DWeM = 0;
        bus.MemReady = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            want_adr = (k % 2 == 0) ? 32'h700 : 32'h600;
            @(negedge clk);
            chk("t6_alt_adr", bus.MemAdr, want_adr);
            tick();
        end
        bus.IReqF = 0; bus.DReqM = 0;
        tick();
        tick();

        // randomized traffic against the model
        iv = 0;
        dv = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            iv = bus.IValidF;
            dv = bus.DValidM;
            tick();
            reset = ($urandom_range(0, 299) == 0);
            bus.MemReady = ($urandom_range(0, 9) < 6);
            bus.MemRdata = $urandom;
            bus.FlushF = 0;
            if (iv || !bus.IReqF) begin
                bus.IReqF = ($urandom_range(0, 2) != 0);
                bus.IAdrF = $urandom & 32'hFFFF_FFFC;
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.FlushF = 1;
                bus.IAdrF = $urandom & 32'hFFFF_FFFC;
            end
            if (dv || !bus.DReqM) begin
                bus.DReqM = ($urandom_range(0, 2) != 0);
                bus.DWeM = $urandom_range(0, 1);
                bus.DAdrM = $urandom;
                bus.DWdataM = $urandom;
                bus.DBeM = $urandom_range(0, 15);
            end
        end

        reset = 0;
        bus.IReqF = 0; bus.DReqM = 0; bus.FlushF = 0;
        tick();
        tick();
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the fetch stage and the memory stage of the five-stage pipeline. It grants one requester at a time, registers the granted address/data, drives the memory handshake and returns read data with a one-cycle valid pulse. It produces per-requester stall signals for the hazard unit and squashes in-flight fetches that a taken branch or jump has made stale.

## Interface
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- IReqF  in  1  fetch request; held high until IValidF
- IAdrF  in  AW  fetch address; stable while IReqF high
- FlushF  in  1  fetch redirect (PCSrcE); squashes the current fetch
- IRdataF  out  DW  fetch read data; meaningful only when IValidF
- IValidF  out  1  fetch completion pulse
- StallF  out  1  fetch must wait
- DReqM  in  1  data request; held high until DValidM
- DWeM  in  1  1 = store, 0 = load
- DAdrM  in  AW  data address
- DWdataM  in  DW  store data
- DBeM  in  DW/8  store byte enables
- DRdataM  out  DW  load data; meaningful only when DValidM
- DValidM  out  1  data completion pulse
- StallM  out  1  data access must wait
- MemReq  out  1  memory request
- MemWe  out  1  memory write
- MemAdr  out  AW  memory address
- MemWdata  out  DW  memory write data
- MemBe  out  DW/8  memory byte enables; all ones for fetch
- MemReady  in  1  memory completes the current access this cycle
- MemRdata  in  DW  memory read data; valid when MemReady

## Operation
- States: IDLE, IBUSY, DBUSY. The reset state is IDLE.
- MemReq = (state != IDLE). MemWe, MemAdr, MemWdata and MemBe come from the registers latched at grant. They are stable for the whole transaction.
- IDLE:
  - If DReqM is high, latch the data request and go to DBUSY.
  - Otherwise, if IReqF is high and FlushF is low, latch IAdrF, set MemWe=0 and MemBe=all ones, and go to IBUSY.
  - Otherwise, stay in IDLE.
- IBUSY or DBUSY with MemReady low: hold the state.
- IBUSY or DBUSY with MemReady high: the transaction completes.
  - If the other requester's Req is high, grant it directly: latch its request and enter its BUSY state (back-to-back).
  - A fetch regrant also requires FlushF low.
  - Otherwise, go to IDLE.
  - The completing requester is never regranted in its own completion cycle.
- IValidF = (state==IBUSY) & MemReady & ~squash. DValidM = (state==DBUSY) & MemReady.
- IRdataF = MemRdata and DRdataM = MemRdata; both are combinational pass-through.
- StallF = IReqF & ~IValidF. StallM = DReqM & ~DValidM.
- squash flag:
  - Set when FlushF is high in IBUSY.
  - Cleared on entry to IBUSY and on reset.
  - While squash is set, the completing fetch gives no IValidF. The memory access itself still completes; it is never aborted.
- FlushF in DBUSY or IDLE has no effect other than blocking a fetch grant in that cycle.
- Any reset: state goes to IDLE, squash is cleared, latched registers go to 0, and MemReq drops in the next cycle. Any in-flight transaction is abandoned, because memory is reset alongside.

## Timing
- Reset values: MemReq=0, MemWe=0, MemAdr=0, MemWdata=0, MemBe=0, IValidF=0, DValidM=0.
- StallF and StallM follow their Req inputs combinationally.
- Minimum latency: Req in cycle N (IDLE), then MemReq in N+1, then Valid in N+1 if MemReady is already high. This gives 2 cycles from request to completion.
- Each extra cycle with MemReady low adds 1 cycle.
- Back-to-back handoff creates no idle bubble: the second MemReq is asserted in the cycle after the first completion.
- Valid signals are single-cycle pulses. A requester must drop Req, or present a new request, in the cycle after its Valid pulse.
- MemReady is ignored in IDLE.

## Configuration
- MEMARB_RR_EN undefined: fixed priority. Data always beats fetch, both in IDLE and at handoff.
- MEMARB_RR_EN defined: adds a 1-bit last-grant register, reset to "fetch".
  - When both requesters are eligible in IDLE, grant the one not granted last.
  - The handoff rule is unchanged. A load/store stream alternates with fetch and cannot starve it.

## Test plan
- Single fetch: IAdrF=0x100, MemReady tied 1 -> MemReq and MemAdr=0x100 in cycle 1; IValidF pulses in cycle 1 with IRdataF=MemRdata; StallF is high in cycle 0 only.
- Store with wait states: DAdrM=0x2000, DWdataM=0xDEADBEEF, DBeM=0x3, MemReady low for 3 cycles -> MemAdr, MemWdata and MemBe are stable for 4 cycles; DValidM pulses once; StallM is high for 4 cycles.
- Simultaneous IReqF and DReqM in IDLE, fixed priority -> data granted first; fetch is granted in the cycle after DValidM with no IDLE cycle between.
- FlushF while fetching 0x40 in IBUSY, then fetch 0x80 -> the 0x40 access completes with no IValidF; 0x80 is then granted, and IValidF pulses with the 0x80 data.
- reset asserted during DBUSY with MemReady low -> the next cycle has state IDLE and MemReq=0; no Valid pulses until a new request.
- MEMARB_RR_EN defined, both requests held continuously -> grants alternate D, I, D, I after reset, starting with data because the reset last-grant is fetch.
